// File: rtl/step_profile_gen_pkg.sv
// Shared motion definitions: FSM states, default widths and direction encoding.
package step_profile_gen_pkg;

  localparam int COUNT_W_DEF  = 16;
  localparam int PERIOD_W_DEF = 24;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/step_period_timer.sv
// Times one step period: registered pulse for the first PULSE_W cycles, strobe on the last cycle.
module step_period_timer #(
  parameter int PERIOD_W = 24,
  parameter int PULSE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                pulse,
  output logic                period_end
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic                active_q, active_d;
  logic                pulse_q, pulse_d;

  assign period_end = active_q && (cnt_q == per_q - PERIOD_W'(1));
  assign pulse      = pulse_q;

  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = '0;
      per_d    = period;
      active_d = 1'b1;
    end else if (clear) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (active_q && !period_end) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
    // Clearing drops the pulse on the next edge, truncating one in progress.
    pulse_d = active_d && (cnt_d < PERIOD_W'(PULSE_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      per_q    <= '0;
      active_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      active_q <= active_d;
      pulse_q  <= pulse_d;
    end
  end

endmodule

// File: rtl/step_profile_gen.sv
// Trapezoidal step-pulse generator with enable/direction sequencing for a stepper phase driver.
module step_profile_gen
  import step_profile_gen_pkg::*;
#(
  parameter int COUNT_W      = COUNT_W_DEF,
  parameter int PERIOD_W     = PERIOD_W_DEF,
  parameter int START_PERIOD = 50000,
  parameter int ACCEL_STEP   = 500,
  parameter int PULSE_W      = 8,
  parameter int SETUP_CYC    = 16,
  parameter int HOLD_CYC     = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] cmd_min_period,
  input  logic                abort,
  output logic                step,
  output logic                direction,
  output logic                enable,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  steps_done
);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] ACCEL_P = PERIOD_W'(ACCEL_STEP);
  localparam logic [PERIOD_W-1:0] FLOOR_P = PERIOD_W'(PULSE_W + 1);

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [COUNT_W-1:0]  steps_q, steps_d;
  logic [COUNT_W-1:0]  ramp_cnt_q, ramp_cnt_d;
  logic [COUNT_W-1:0]  steps_done_q, steps_done_d;
  logic [PERIOD_W-1:0] eff_min_q, eff_min_d;
  logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic                enable_q, enable_d;
  logic                done_q, done_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;

  logic                tmr_load, tmr_clear, tmr_pulse, tmr_end;
  logic [COUNT_W-1:0]  rem;
  logic [PERIOD_W:0]   slow_sum;
  logic [PERIOD_W-1:0] slow_per, fast_diff, fast_per;

  step_period_timer #(
    .PERIOD_W (PERIOD_W),
    .PULSE_W  (PULSE_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .clear      (tmr_clear),
    .period     (cur_period_d),
    .pulse      (tmr_pulse),
    .period_end (tmr_end)
  );

  // Saturating ramp candidates: one step slower (capped at START) and one step faster (floored at eff_min).
  always_comb begin
    rem       = steps_q - steps_done_q;
    slow_sum  = {1'b0, cur_period_q} + {1'b0, ACCEL_P};
    slow_per  = (slow_sum > {1'b0, START_P}) ? START_P : slow_sum[PERIOD_W-1:0];
    fast_diff = (cur_period_q > ACCEL_P) ? (cur_period_q - ACCEL_P) : '0;
    fast_per  = (fast_diff < eff_min_q) ? eff_min_q : fast_diff;
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    steps_d      = steps_q;
    ramp_cnt_d   = ramp_cnt_q;
    steps_done_d = steps_done_q;
    eff_min_d    = eff_min_q;
    cur_period_d = cur_period_q;
    phase_d      = phase_q;
    enable_d     = enable_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          dir_d        = cmd_dir ? DIR_FWD : DIR_REV;
          steps_d      = cmd_steps;
          eff_min_d    = (cmd_min_period < FLOOR_P) ? FLOOR_P :
                         (cmd_min_period > START_P) ? START_P : cmd_min_period;
          cur_period_d = START_P;
          ramp_cnt_d   = '0;
          steps_done_d = '0;
          phase_d      = '0;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_SETUP;
            enable_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (abort) begin
          state_d = ST_HOLD;
          phase_d = '0;
        end else if (phase_q == PERIOD_W'(SETUP_CYC - 1)) begin
          state_d      = ST_RUN;
          tmr_load     = 1'b1;
          steps_done_d = steps_done_q + COUNT_W'(1);
        end else begin
          phase_d = phase_q + PERIOD_W'(1);
        end
      end
      ST_RUN: begin
        if (abort || (tmr_end && rem == '0)) begin
          state_d   = ST_HOLD;
          tmr_clear = 1'b1;
          phase_d   = '0;
        end else if (tmr_end) begin
          if (rem <= ramp_cnt_q) begin
            cur_period_d = slow_per;
            ramp_cnt_d   = ramp_cnt_q - COUNT_W'(1);
          end else if (cur_period_q > eff_min_q) begin
            cur_period_d = fast_per;
            ramp_cnt_d   = ramp_cnt_q + COUNT_W'(1);
          end
          tmr_load     = 1'b1;
          steps_done_d = steps_done_q + COUNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (phase_q == PERIOD_W'(HOLD_CYC - 1)) begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          phase_d = phase_q + PERIOD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_REV;
      steps_q      <= '0;
      ramp_cnt_q   <= '0;
      steps_done_q <= '0;
      eff_min_q    <= '0;
      cur_period_q <= '0;
      phase_q      <= '0;
      enable_q     <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      steps_q      <= steps_d;
      ramp_cnt_q   <= ramp_cnt_d;
      steps_done_q <= steps_done_d;
      eff_min_q    <= eff_min_d;
      cur_period_q <= cur_period_d;
      phase_q      <= phase_d;
      enable_q     <= enable_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign step       = tmr_pulse;
  assign direction  = dir_q;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmd_ready  = cmd_ready_q;
  assign steps_done = steps_done_q;

endmodule

// File: tb/tb_step_profile_gen.sv
// Self-checking bench for step_profile_gen with a small-parameter build and a profile model.
module tb_step_profile_gen;
  import step_profile_gen_pkg::*;

  localparam int SP = 100;
  localparam int AS = 20;
  localparam int PW = 4;
  localparam int SC = 4;
  localparam int HC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [23:0] cmd_min_period = '0;
  logic        cmd_ready, step, direction, enable, busy, done;
  logic [15:0] steps_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_per[$];
  int rise[$];
  int hi_len[$];
  int acc_cyc, done_cyc, done_cnt, en_cnt, dir_bad, ready_bad, abort_cyc, timeout;
  logic [15:0] sd_end;
  logic        post_ok;

  step_profile_gen #(
    .COUNT_W(16), .PERIOD_W(24), .START_PERIOD(SP), .ACCEL_STEP(AS),
    .PULSE_W(PW), .SETUP_CYC(SC), .HOLD_CYC(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_min_period(cmd_min_period),
    .abort(abort), .step(step), .direction(direction), .enable(enable),
    .busy(busy), .done(done), .steps_done(steps_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference profile: list of step periods obtained by applying the ramp rules step by step.
  function automatic void model(input int steps, input int minp);
    int eff, cur, ramp;
    exp_per.delete();
    eff = (minp < PW + 1) ? PW + 1 : ((minp > SP) ? SP : minp);
    cur = SP;
    ramp = 0;
    for (int i = 1; i <= steps; i++) begin
      exp_per.push_back(cur);
      if (steps - i == 0) break;
      if (steps - i <= ramp) begin
        cur = (cur + AS > SP) ? SP : cur + AS;
        ramp--;
      end else if (cur > eff) begin
        cur = (cur - AS < eff) ? eff : cur - AS;
        ramp++;
      end
    end
  endfunction

  function automatic int per_sum(input int n);
    int s = 0;
    for (int k = 0; k < n; k++) s += exp_per[k];
    return s;
  endfunction

  function automatic int rise_errs(input int n);
    int t, e;
    t = acc_cyc + SC;
    e = 0;
    if (rise.size() != n) return 1000 + rise.size();
    for (int k = 0; k < n; k++) begin
      if (rise[k] != t) e++;
      t += exp_per[k];
    end
    return e;
  endfunction

  function automatic int bad_pulses();
    int e = 0;
    foreach (hi_len[k]) if (hi_len[k] != PW) e++;
    return e;
  endfunction

  task automatic run_move(input int steps, input logic dir, input int minp,
                          input int abort_after, input bit keep_valid);
    int   hi;
    logic prev;
    hi = 0;
    prev = 1'b0;
    rise.delete();
    hi_len.delete();
    done_cnt = 0; en_cnt = 0; dir_bad = 0; ready_bad = 0;
    timeout = 0; abort_cyc = -1; done_cyc = -1; sd_end = '1;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_steps = 16'(steps);
    cmd_dir = dir;
    cmd_min_period = 24'(minp);
    @(negedge clk);
    acc_cyc = cyc;
    if (!keep_valid) cmd_valid = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      if (step && !prev) rise.push_back(cyc);
      if (step) hi++;
      else if (prev) begin
        hi_len.push_back(hi);
        hi = 0;
      end
      prev = step;
      if (enable) en_cnt++;
      if (enable && direction !== dir) dir_bad++;
      if (busy && cmd_ready) ready_bad++;
      abort = 1'b0;
      if (abort_after > 0 && rise.size() == abort_after) begin
        if (cyc == rise[abort_after-1] + 2) begin
          abort = 1'b1;
          abort_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        sd_end = steps_done;
        cmd_valid = 1'b0;
        break;
      end
      @(negedge clk);
      if (n == 5999) timeout = 1;
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    post_ok = !done && !enable && !busy && cmd_ready && !step;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({step, enable, busy, done, direction} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {step, enable, busy, done, direction});
    end
    checks++;
    if (cmd_ready !== 1'b0 || steps_done !== 16'd0) begin
      failures++;
      $display("FAIL reset_ready_count got=%b/%0d exp=0/0", cmd_ready, steps_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_trapezoid();
    model(10, 40);
    run_move(10, DIR_FWD, 40, 0, 0);
    checks++;
    if (rise_errs(10) != 0) begin
      failures++;
      $display("FAIL trap_edges got=%0d errors exp=0", rise_errs(10));
    end
    checks++;
    if (rise.size() == 10 && rise[9] - rise[0] != 540) begin
      failures++;
      $display("FAIL trap_span got=%0d exp=540", rise[9] - rise[0]);
    end
    checks++;
    if (sd_end !== 16'd10 || done_cnt != 1) begin
      failures++;
      $display("FAIL trap_done got steps=%0d done=%0d exp steps=10 done=1", sd_end, done_cnt);
    end
    checks++;
    if (done_cyc != acc_cyc + SC + per_sum(10) + HC || timeout != 0) begin
      failures++;
      $display("FAIL trap_done_time got=%0d exp=%0d", done_cyc - acc_cyc, SC + per_sum(10) + HC);
    end
    checks++;
    if (en_cnt != done_cyc - acc_cyc || dir_bad != 0) begin
      failures++;
      $display("FAIL trap_enable got en=%0d dirbad=%0d exp en=%0d dirbad=0", en_cnt, dir_bad, done_cyc - acc_cyc);
    end
    checks++;
    if (bad_pulses() != 0 || hi_len.size() != 10 || !post_ok) begin
      failures++;
      $display("FAIL trap_pulses got bad=%0d n=%0d post=%b exp 0/10/1", bad_pulses(), hi_len.size(), post_ok);
    end
  endtask

  task automatic test_short_move();
    model(3, 40);
    run_move(3, DIR_FWD, 40, 0, 0);
    checks++;
    if (rise_errs(3) != 0 || sd_end !== 16'd3) begin
      failures++;
      $display("FAIL short_move got errs=%0d steps=%0d exp 0/3", rise_errs(3), sd_end);
    end
    checks++;
    if (rise.size() == 3 && rise[2] - rise[1] != 80) begin
      failures++;
      $display("FAIL short_mid_period got=%0d exp=80", rise[2] - rise[1]);
    end
  endtask

  task automatic test_edge_cases();
    int mind;
    run_move(0, DIR_FWD, 40, 0, 0);
    checks++;
    if (done_cyc != acc_cyc || en_cnt != 0 || sd_end !== 16'd0 || rise.size() != 0) begin
      failures++;
      $display("FAIL zero_steps got dt=%0d en=%0d steps=%0d exp 0/0/0", done_cyc - acc_cyc, en_cnt, sd_end);
    end
    model(12, 2);
    run_move(12, DIR_REV, 2, 0, 0);
    mind = 1 << 30;
    for (int k = 1; k < rise.size(); k++) if (rise[k] - rise[k-1] < mind) mind = rise[k] - rise[k-1];
    checks++;
    if (mind != 5 || rise_errs(12) != 0) begin
      failures++;
      $display("FAIL min_clamp got min=%0d errs=%0d exp min=5 errs=0", mind, rise_errs(12));
    end
    checks++;
    if (bad_pulses() != 0 || dir_bad != 0) begin
      failures++;
      $display("FAIL min_clamp_pulses got bad=%0d dirbad=%0d exp 0/0", bad_pulses(), dir_bad);
    end
    model(6, 500);
    run_move(6, DIR_FWD, 500, 0, 0);
    checks++;
    if (rise.size() != 6 || rise[5] - rise[0] != 500 || rise_errs(6) != 0) begin
      failures++;
      $display("FAIL max_clamp got n=%0d errs=%0d exp n=6 span=500", rise.size(), rise_errs(6));
    end
  endtask

  task automatic test_abort();
    model(10, 40);
    run_move(10, DIR_FWD, 40, 5, 0);
    checks++;
    if (sd_end !== 16'd5 || rise.size() != 5) begin
      failures++;
      $display("FAIL abort_count got steps=%0d rises=%0d exp 5/5", sd_end, rise.size());
    end
    checks++;
    if (hi_len.size() != 5 || hi_len[4] != 3) begin
      failures++;
      $display("FAIL abort_truncate got n=%0d exp last pulse=3", hi_len.size());
    end
    checks++;
    if (abort_cyc < 0 || done_cyc != abort_cyc + 1 + HC || done_cnt != 1) begin
      failures++;
      $display("FAIL abort_hold got=%0d exp=%0d", done_cyc - abort_cyc, 1 + HC);
    end
    checks++;
    if (en_cnt != done_cyc - acc_cyc || !post_ok) begin
      failures++;
      $display("FAIL abort_enable got en=%0d post=%b exp en=%0d post=1", en_cnt, post_ok, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_busy_ignore();
    model(5, 60);
    run_move(5, DIR_REV, 60, 0, 1);
    checks++;
    if (ready_bad != 0 || done_cnt != 1 || !post_ok) begin
      failures++;
      $display("FAIL busy_ignore got readybad=%0d done=%0d post=%b exp 0/1/1", ready_bad, done_cnt, post_ok);
    end
    checks++;
    if (rise_errs(5) != 0 || dir_bad != 0 || direction !== DIR_REV) begin
      failures++;
      $display("FAIL busy_move got errs=%0d dirbad=%0d exp 0/0", rise_errs(5), dir_bad);
    end
  endtask

  task automatic test_random_moves();
    int st, mp;
    logic d;
    for (int it = 0; it < 5; it++) begin
      st = $urandom_range(12, 1);
      mp = $urandom_range(130, 1);
      d = 1'($urandom_range(1, 0));
      model(st, mp);
      run_move(st, d, mp, 0, 0);
      checks++;
      if (rise_errs(st) != 0 || sd_end !== 16'(st) || dir_bad != 0 ||
          done_cyc != acc_cyc + SC + per_sum(st) + HC) begin
        failures++;
        $display("FAIL random_move steps=%0d min=%0d got errs=%0d sd=%0d dt=%0d exp 0/%0d/%0d",
                 st, mp, rise_errs(st), sd_end, done_cyc - acc_cyc, st, SC + per_sum(st) + HC);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 16'd10; cmd_dir = DIR_FWD; cmd_min_period = 24'd40;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(steps_done >= 16'd2 && step) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL midrun_wait got timeout exp second step");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({step, enable, busy, direction} !== 4'b0) begin
      failures++;
      $display("FAIL midrun_reset got=%b exp=0000", {step, enable, busy, direction});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || steps_done !== 16'd0 || enable !== 1'b0) begin
      failures++;
      $display("FAIL midrun_release got ready=%b sd=%0d en=%b exp 1/0/0", cmd_ready, steps_done, enable);
    end
  endtask

  initial begin
    test_reset();
    test_trapezoid();
    test_short_move();
    test_edge_cases();
    test_abort();
    test_busy_ignore();
    test_random_moves();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
